// File: rtl/alu_exec_seq.sv
`default_nettype none
// ============================================================================
// alu_exec_seq: five-state execute sequencer (read A, read B, exec, write back)
// looped around an 8x16 register file. Revision: 1.0
// ============================================================================
module alu_exec_seq #(
  parameter int W  = 16,
  parameter int RB = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [1:0]    shift,
  input  logic [RB-1:0] rn,
  input  logic [RB-1:0] rm,
  input  logic [RB-1:0] rd,
  input  logic          wb,
  input  logic [W-1:0]  rf_data_out,
  output logic [RB-1:0] rf_readnum,
  output logic [RB-1:0] rf_writenum,
  output logic          rf_write,
  output logic [W-1:0]  rf_data_in,
  output logic          busy,
  output logic          done,
  output logic          Z,
  output logic          N,
  output logic          V
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  c_q;
  logic [RB-1:0] rn_l;
  logic [RB-1:0] rm_l;
  logic [RB-1:0] rd_l;
  logic [1:0]    op_l;
  logic [1:0]    shift_l;
  logic          wb_l;

  logic [W-1:0]  bsh;
  logic [W-1:0]  bop;
  logic [W-1:0]  alu_res;
  logic          alu_v;

  always_comb begin
    bsh = b_q;
    case (shift_l)
      2'b01:   bsh = {b_q[W-2:0], 1'b0};
      2'b10:   bsh = {1'b0, b_q[W-1:1]};
      2'b11:   bsh = {b_q[W-1], b_q[W-1:1]};
      default: bsh = b_q;
    endcase

    bop     = (op_l == OP_SUB) ? ~bsh : bsh;
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_l)
      OP_ADD:  alu_res = a_q + bsh;
      OP_SUB:  alu_res = a_q - bsh;
      OP_AND:  alu_res = a_q & bsh;
      OP_MVN:  alu_res = ~bsh;
      default: alu_res = '0;
    endcase

    // Overflow: operands (as seen by the adder) agree in sign, result does not.
    if (op_l == OP_ADD || op_l == OP_SUB)
      alu_v = (a_q[W-1] == bop[W-1]) && (alu_res[W-1] != a_q[W-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      rn_l    <= '0;
      rm_l    <= '0;
      rd_l    <= '0;
      op_l    <= '0;
      shift_l <= '0;
      wb_l    <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_l    <= op;
            shift_l <= shift;
            rn_l    <= rn;
            rm_l    <= rm;
            rd_l    <= rd;
            wb_l    <= wb;
          end
        end
        S_READ_A: a_q <= rf_data_out;
        S_READ_B: b_q <= rf_data_out;
        S_EXEC: begin
          c_q <= alu_res;
          Z   <= (alu_res == '0);
          N   <= alu_res[W-1];
          V   <= alu_v;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    rf_readnum  = '0;
    rf_writenum = '0;
    rf_write    = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:   if (start) state_nx = S_READ_A;
      S_READ_A: begin
        rf_readnum = rn_l;
        state_nx   = S_READ_B;
      end
      S_READ_B: begin
        rf_readnum = rm_l;
        state_nx   = S_EXEC;
      end
      S_EXEC:   state_nx = S_WRITE;
      S_WRITE: begin
        rf_writenum = rd_l;
        rf_write    = wb_l;
        done        = 1'b1;
        state_nx    = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  assign rf_data_in = c_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_seq: register-file environment, directed table, corner sequences
// and randomized ops against an arithmetic reference model. Revision: 1.0
// ============================================================================
module tb_alu_exec_seq;
  localparam int W  = 16;
  localparam int RB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [1:0]    shift;
  logic [RB-1:0] rn;
  logic [RB-1:0] rm;
  logic [RB-1:0] rd;
  logic          wb;
  logic [W-1:0]  rf_data_out;
  logic [RB-1:0] rf_readnum;
  logic [RB-1:0] rf_writenum;
  logic          rf_write;
  logic [W-1:0]  rf_data_in;
  logic          busy;
  logic          done;
  logic          Z;
  logic          N;
  logic          V;

  always #5 clk = ~clk;

  alu_exec_seq #(.W(W), .RB(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
    .rn(rn), .rm(rm), .rd(rd), .wb(wb), .rf_data_out(rf_data_out),
    .rf_readnum(rf_readnum), .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .busy(busy), .done(done), .Z(Z), .N(N), .V(V)
  );

  // Register file environment: combinational read, write at rising edge.
  logic [W-1:0]  rf [8];
  logic          pre_en = 1'b0;
  logic [RB-1:0] pre_addr = '0;
  logic [W-1:0]  pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (rf_write) rf[rf_writenum] <= rf_data_in;
  end
  assign rf_data_out = rf[rf_readnum];

  logic [W-1:0] mregs [8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [RB-1:0] addr, input logic [W-1:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = addr; pre_data = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
    mregs[addr] = val;
  endtask

  // Returns {V, N, Z, result} from signed/unsigned integer arithmetic.
  function automatic logic [18:0] ref_model(input logic [1:0] o, input logic [1:0] sh,
                                             input logic [15:0] a, input logic [15:0] b);
    int ua, ub, bs, sa, sb, r;
    logic v;
    logic [15:0] res;
    ua = a; ub = b; v = 1'b0; r = 0;
    case (sh)
      2'd0:    bs = ub;
      2'd1:    bs = (ub * 2) % 65536;
      2'd2:    bs = ub / 2;
      default: bs = (ub >= 32768) ? ub / 2 + 32768 : ub / 2;
    endcase
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (bs >= 32768) ? bs - 65536 : bs;
    case (o)
      2'd0:    begin r = sa + sb; v = (r > 32767) || (r < -32768); end
      2'd1:    begin r = sa - sb; v = (r > 32767) || (r < -32768); end
      2'd2:    r = ua & bs;
      default: r = 65535 - bs;
    endcase
    res = r[15:0];
    return {v, res[15], (res == 16'h0), res};
  endfunction

  task automatic check_regs(input string tag);
    int bad = 0;
    for (int i = 0; i < 8; i++) if (rf[i] !== mregs[i]) bad++;
    chk({tag, ".regs_mismatched"}, 32'(bad), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [1:0] sh, input logic [RB-1:0] a_r,
                        input logic [RB-1:0] b_r, input logic [RB-1:0] d_r, input logic w,
                        input logic [15:0] eres, input logic ez, input logic en, input logic ev,
                        input string tag);
    @(negedge clk);
    start = 1'b1; op = o; shift = sh; rn = a_r; rm = b_r; rd = d_r; wb = w;
    @(posedge clk); #1;
    // Scramble request fields so only the latched copies can matter.
    start = 1'b0; op = 2'($urandom); shift = 2'($urandom);
    rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom); wb = 1'($urandom);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done"}, 32'(done), 32'(k == 4));
      chk({tag, ".rf_write"}, 32'(rf_write), 32'((k == 4) && w));
      if (k == 4) begin
        chk({tag, ".rf_data_in"}, 32'(rf_data_in), 32'(eres));
        if (w) chk({tag, ".rf_writenum"}, 32'(rf_writenum), 32'(d_r));
      end
    end
    @(posedge clk); #1;
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".ZNV"}, 32'({Z, N, V}), 32'({ez, en, ev}));
    if (w) mregs[d_r] = eres;
    check_regs(tag);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic        wb;
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] e;
    int dones;
    logic saw_wr;
    logic [15:0] pick;

    tbl[0] = '{2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 2'd0, 3'd1, 3'd2, 3'd4, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{2'd1, 2'd0, 3'd5, 3'd6, 3'd0, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2'd3, 2'd1, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0000, 16'h8001, 16'hFFFD, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{2'd3, 2'd2, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0000, 16'h8001, 16'hBFFF, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{2'd3, 2'd3, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0000, 16'h8001, 16'h3FFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{2'd2, 2'd0, 3'd7, 3'd7, 3'd7, 1'b1, 16'h00F0, 16'h00F0, 16'h00F0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{2'd0, 2'd0, 3'd7, 3'd7, 3'd7, 1'b1, 16'h00F0, 16'h00F0, 16'h01E0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; shift = '0; rn = '0; rm = '0; rd = '0; wb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", 32'({busy, done, rf_write, Z, N, V}), 32'd0);
    chk("reset.selects", 32'({rf_readnum, rf_writenum}), 32'd0);
    chk("reset.rf_data_in", 32'(rf_data_in), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);

    for (int i = 0; i < 8; i++) begin
      preload(tbl[i].rn, tbl[i].av);
      preload(tbl[i].rm, tbl[i].bv);
      run_op(tbl[i].op, tbl[i].sh, tbl[i].rn, tbl[i].rm, tbl[i].rd, tbl[i].wb,
             tbl[i].res, tbl[i].z, tbl[i].n, tbl[i].v, $sformatf("vec%0d", i));
    end

    // start raised during READ_B/EXEC must not queue a second operation.
    @(negedge clk);
    start = 1'b1; op = 2'd0; shift = 2'd0; rn = 3'd1; rm = 3'd2; rd = 3'd0; wb = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) start = 1'b1;
      if (k == 4) start = 1'b0;
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("busy_start.dones", 32'(dones), 32'd1);
    chk("busy_start.idle", 32'(busy), 32'd0);

    // start held high: one operation every five cycles.
    @(negedge clk);
    start = 1'b1; op = 2'd0; shift = 2'd0; rn = 3'd1; rm = 3'd2; rd = 3'd0; wb = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      chk($sformatf("held.done_k%0d", k), 32'(done), 32'((k % 5) == 3));
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("held.idle", 32'(busy), 32'd0);
    check_regs("held");

    // Reset while in EXEC: abandon the op, clear flags, no write.
    preload(3'd1, 16'h8000);
    preload(3'd2, 16'h0001);
    run_op(2'd1, 2'd0, 3'd1, 3'd2, 3'd4, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1, "pre_rst");
    preload(3'd3, 16'hA5A5);
    @(negedge clk);
    start = 1'b1; op = 2'd0; shift = 2'd0; rn = 3'd1; rm = 3'd2; rd = 3'd3; wb = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_exec.busy", 32'(busy), 32'd0);
    chk("rst_exec.ZNV", 32'({Z, N, V}), 32'd0);
    chk("rst_exec.rf_write", 32'(rf_write), 32'd0);
    reset = 1'b0;
    saw_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rf_write || done) saw_wr = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_exec.no_write", 32'(saw_wr), 32'd0);
    check_regs("rst_exec");

    // Randomized operations against the reference model.
    for (int i = 0; i < 48; i++) begin
      if (i % 12 == 0) begin
        for (int r = 0; r < 8; r++) begin
          case ($urandom_range(0, 5))
            0:       pick = 16'h0000;
            1:       pick = 16'h7FFF;
            2:       pick = 16'h8000;
            3:       pick = 16'hFFFF;
            default: pick = 16'($urandom);
          endcase
          preload(3'(r), pick);
        end
      end
      op = 2'($urandom); shift = 2'($urandom);
      rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom); wb = 1'($urandom_range(0, 1));
      e = ref_model(op, shift, mregs[rn], mregs[rm]);
      run_op(op, shift, rn, rm, rd, wb, e[15:0], e[16], e[17], e[18], $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
